// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle between a producer/consumer pair and sync_fifo_param.
// slave modport is the FIFO side, master modport is the user side.
interface sync_fifo_param_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             wr_en_i;
    logic [WIDTH-1:0] wdata_i;
    logic             rd_en_i;
    logic [WIDTH-1:0] rdata_o;
    logic             full_o;
    logic             empty_o;
    logic             almost_full_o;
    logic             almost_empty_o;
    logic [CNT_W-1:0] count_o;
    logic             wr_error_o;
    logic             rd_error_o;

    modport slave (
        input  wr_en_i, wdata_i, rd_en_i,
        output rdata_o, full_o, empty_o, almost_full_o, almost_empty_o,
        output count_o, wr_error_o, rd_error_o
    );

    modport master (
        output wr_en_i, wdata_i, rd_en_i,
        input  rdata_o, full_o, empty_o, almost_full_o, almost_empty_o,
        input  count_o, wr_error_o, rd_error_o
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock power-of-two FIFO with wrap-bit pointers, occupancy count and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is registered read.
module sync_fifo_param #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2
) (
    input logic               clk_i,
    input logic               rst_i,
    sync_fifo_param_if.slave  fifo_if
);
    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
    localparam logic [PTR_WIDTH:0] PTR_ONE = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH:0] AF_LVL  = (PTR_WIDTH+1)'(AF_THRESH);
    localparam logic [PTR_WIDTH:0] AE_LVL  = (PTR_WIDTH+1)'(AE_THRESH);

    logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic               wr_error_q, wr_error_d;
    logic               rd_error_q, rd_error_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];

    logic [PTR_WIDTH:0] count;
    logic               full, empty, wr_accept, rd_accept;

    // Modular subtraction stays correct across any number of pointer wraps.
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]) &&
                   (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]);

    assign wr_accept = fifo_if.wr_en_i && !full;
    assign rd_accept = fifo_if.rd_en_i && !empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;
        wr_error_d = fifo_if.wr_en_i && full;
        rd_error_d = fifo_if.rd_en_i && empty;
        if (wr_accept) begin
            mem_d[wr_ptr_q[PTR_WIDTH-1:0]] = fifo_if.wdata_i;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_error_q <= 1'b0;
            rd_error_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_error_q <= wr_error_d;
            rd_error_q <= rd_error_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign fifo_if.rdata_o = empty ? '0 : mem_q[rd_ptr_q[PTR_WIDTH-1:0]];
`else
    logic [WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (rd_accept) begin
            rdata_d = mem_q[rd_ptr_q[PTR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign fifo_if.rdata_o = rdata_q;
`endif

    assign fifo_if.full_o         = full;
    assign fifo_if.empty_o        = empty;
    assign fifo_if.count_o        = count;
    assign fifo_if.almost_full_o  = (count >= AF_LVL);
    assign fifo_if.almost_empty_o = (count <= AE_LVL);
    assign fifo_if.wr_error_o     = wr_error_q;
    assign fifo_if.rd_error_o     = rd_error_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a 16x8 default instance and a 4x32 instance.
// Expectations follow SYNC_FIFO_FWFT_EN when it is defined.
module tb_sync_fifo_param;
    logic clk_i;
    logic rst_i;

    sync_fifo_param_if #(.WIDTH(8),  .DEPTH(16)) bus_a ();
    sync_fifo_param_if #(.WIDTH(32), .DEPTH(4))  bus_b ();

    sync_fifo_param u_dut_a (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .fifo_if (bus_a)
    );

    sync_fifo_param #(
        .WIDTH     (32),
        .DEPTH     (4),
        .AF_THRESH (3),
        .AE_THRESH (1)
    ) u_dut_b (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .fifo_if (bus_b)
    );

    int unsigned n_checks;
    int unsigned n_fails;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_i = 1'b0;
        bus_a.wr_en_i = 1'b0; bus_a.rd_en_i = 1'b0; bus_a.wdata_i = '0;
        bus_b.wr_en_i = 1'b0; bus_b.rd_en_i = 1'b0; bus_b.wdata_i = '0;
        #12;
        check_eq("rst_count", 64'(bus_a.count_o), 64'(0));
        check_eq("rst_empty", 64'(bus_a.empty_o), 64'(1));
        check_eq("rst_ae",    64'(bus_a.almost_empty_o), 64'(1));
        check_eq("rst_full",  64'(bus_a.full_o), 64'(0));
        check_eq("rst_af",    64'(bus_a.almost_full_o), 64'(0));
        check_eq("rst_errs",  64'({bus_a.wr_error_o, bus_a.rd_error_o}), 64'(0));
        check_eq("rst_rdata", 64'(bus_a.rdata_o), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b1;

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            bus_a.wr_en_i = 1'b1;
            bus_a.wdata_i = 8'(i);
            step();
            check_eq("fill_count", 64'(bus_a.count_o), 64'(i + 1));
            check_eq("fill_af", 64'(bus_a.almost_full_o), 64'((i + 1) >= 14));
        end
        check_eq("fill_full", 64'(bus_a.full_o), 64'(1));
        bus_a.wdata_i = 8'hFF;
        step();
        check_eq("ovf_wr_err", 64'(bus_a.wr_error_o), 64'(1));
        check_eq("ovf_count", 64'(bus_a.count_o), 64'(16));
        bus_a.wr_en_i = 1'b0;
        step();
        check_eq("ovf_wr_err_clr", 64'(bus_a.wr_error_o), 64'(0));

        // Drain in order
        for (int i = 0; i < 16; i++) begin
            bus_a.rd_en_i = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
            check_eq("drain_data", 64'(bus_a.rdata_o), 64'(i));
            step();
`else
            step();
            check_eq("drain_data", 64'(bus_a.rdata_o), 64'(i));
`endif
        end
        check_eq("drain_empty", 64'(bus_a.empty_o), 64'(1));
        step();
        check_eq("udf_rd_err", 64'(bus_a.rd_error_o), 64'(1));
`ifdef SYNC_FIFO_FWFT_EN
        check_eq("udf_rdata", 64'(bus_a.rdata_o), 64'(0));
`else
        check_eq("udf_rdata", 64'(bus_a.rdata_o), 64'(8'h0F));
`endif
        bus_a.rd_en_i = 1'b0;
        step();
        check_eq("udf_rd_err_clr", 64'(bus_a.rd_error_o), 64'(0));

        // Preload 5 words then stream 40 cycles across the pointer wrap
        for (int i = 0; i < 5; i++) begin
            bus_a.wr_en_i = 1'b1;
            bus_a.wdata_i = 8'(i);
            step();
        end
        check_eq("pre_count", 64'(bus_a.count_o), 64'(5));
        for (int i = 0; i < 40; i++) begin
            bus_a.wr_en_i = 1'b1;
            bus_a.rd_en_i = 1'b1;
            bus_a.wdata_i = 8'(i + 5);
`ifdef SYNC_FIFO_FWFT_EN
            check_eq("stream_data", 64'(bus_a.rdata_o), 64'(i));
            step();
`else
            step();
            check_eq("stream_data", 64'(bus_a.rdata_o), 64'(i));
`endif
            check_eq("stream_count", 64'(bus_a.count_o), 64'(5));
            check_eq("stream_errs", 64'({bus_a.wr_error_o, bus_a.rd_error_o}), 64'(0));
        end

        // Top up to full (40..44 remain, add 0x80..0x8A)
        bus_a.rd_en_i = 1'b0;
        for (int i = 0; i < 11; i++) begin
            bus_a.wdata_i = 8'(8'h80 + i);
            step();
        end
        check_eq("top_full", 64'(bus_a.full_o), 64'(1));
        bus_a.wdata_i = 8'h77;
        bus_a.rd_en_i = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
        check_eq("full_rw_data", 64'(bus_a.rdata_o), 64'(40));
        step();
`else
        step();
        check_eq("full_rw_data", 64'(bus_a.rdata_o), 64'(40));
`endif
        check_eq("full_rw_err", 64'(bus_a.wr_error_o), 64'(1));
        check_eq("full_rw_count", 64'(bus_a.count_o), 64'(15));
        bus_a.wr_en_i = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check_eq("drain2_empty", 64'(bus_a.empty_o), 64'(1));
        bus_a.wr_en_i = 1'b1;
        bus_a.wdata_i = 8'h3C;
        step();
        check_eq("empty_rw_err", 64'(bus_a.rd_error_o), 64'(1));
        check_eq("empty_rw_count", 64'(bus_a.count_o), 64'(1));
`ifdef SYNC_FIFO_FWFT_EN
        check_eq("empty_rw_rdata", 64'(bus_a.rdata_o), 64'(8'h3C));
`else
        check_eq("empty_rw_rdata", 64'(bus_a.rdata_o), 64'(8'h8A));
`endif
        bus_a.rd_en_i = 1'b0;

        // Asynchronous reset at count 9
        for (int i = 0; i < 8; i++) begin
            bus_a.wdata_i = 8'(8'h40 + i);
            step();
        end
        bus_a.wr_en_i = 1'b0;
        check_eq("pre_rst_count", 64'(bus_a.count_o), 64'(9));
        #2 rst_i = 1'b0;
        #1;
        check_eq("arst_count", 64'(bus_a.count_o), 64'(0));
        check_eq("arst_empty", 64'(bus_a.empty_o), 64'(1));
        check_eq("arst_rdata", 64'(bus_a.rdata_o), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b1;
        bus_a.wr_en_i = 1'b1;
        bus_a.wdata_i = 8'hA5;
        step();
        bus_a.wr_en_i = 1'b0;
        check_eq("post_rst_count", 64'(bus_a.count_o), 64'(1));
        bus_a.rd_en_i = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
        check_eq("post_rst_data", 64'(bus_a.rdata_o), 64'(8'hA5));
        step();
`else
        step();
        check_eq("post_rst_data", 64'(bus_a.rdata_o), 64'(8'hA5));
`endif
        bus_a.rd_en_i = 1'b0;
        check_eq("post_rst_empty", 64'(bus_a.empty_o), 64'(1));

        // Small instance: DEPTH=4, AF=3, AE=1
        check_eq("b_count0", 64'(bus_b.count_o), 64'(0));
        check_eq("b_ae0", 64'(bus_b.almost_empty_o), 64'(1));
        check_eq("b_af0", 64'(bus_b.almost_full_o), 64'(0));
        for (int k = 1; k <= 4; k++) begin
            bus_b.wr_en_i = 1'b1;
            bus_b.wdata_i = 32'hDEAD0000 + 32'(k);
            step();
            check_eq("b_wr_count", 64'(bus_b.count_o), 64'(k));
            check_eq("b_wr_af", 64'(bus_b.almost_full_o), 64'(k >= 3));
            check_eq("b_wr_ae", 64'(bus_b.almost_empty_o), 64'(k <= 1));
            check_eq("b_wr_full", 64'(bus_b.full_o), 64'(k == 4));
        end
        step();
        check_eq("b_ovf", 64'(bus_b.wr_error_o), 64'(1));
        bus_b.wr_en_i = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            bus_b.rd_en_i = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
            if (k == 3) check_eq("b_rd_data", 64'(bus_b.rdata_o), 64'(32'hDEAD0001));
            step();
`else
            step();
            if (k == 3) check_eq("b_rd_data", 64'(bus_b.rdata_o), 64'(32'hDEAD0001));
`endif
            check_eq("b_rd_count", 64'(bus_b.count_o), 64'(k));
            check_eq("b_rd_ae", 64'(bus_b.almost_empty_o), 64'(k <= 1));
            check_eq("b_rd_af", 64'(bus_b.almost_full_o), 64'(k >= 3));
        end
        bus_b.rd_en_i = 1'b0;
        check_eq("b_empty", 64'(bus_b.empty_o), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
